oled_frame_arbiter: RTL and testbench

Shares the single ST7735 OLED pixel stream between two pixel sources, e.g. a hex_decoder status page and a second renderer. Sits between the sources and oled_video. Fans out the scan coordinates, forwards `next_pixel` only to the owning source, and muxes that source's color. Ownership changes only at frame boundaries, so a frame is never split between sources.

---
 rtl/oled_frame_arbiter.sv | 129 ++++++++++++
 tb/tb_oled_frame_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_arbiter.sv
// Shares one oled_video pixel stream between two sources. Ownership only
// changes on the frame end event, so a frame is never split between sources.
module oled_frame_arbiter #(
    parameter int                      C_color_bits  = 16,
    parameter int                      C_x_max       = 127,
    parameter int                      C_y_max       = 159,
    parameter int                      C_hold_frames = 2,
    parameter logic [C_color_bits-1:0] C_idle_color  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              x,
    input  logic [7:0]              y,
    input  logic                    next_pixel,
    output logic [C_color_bits-1:0] color,
    input  logic [1:0]              req,
    input  logic [C_color_bits-1:0] src0_color,
    input  logic [C_color_bits-1:0] src1_color,
    output logic [1:0]              src_next_pixel,
    output logic [1:0]              grant,
    output logic                    frame_end
);

    // Strobe contract: next_pixel=1 means oled_video consumed the pixel at (x,y)
    // this cycle; the owning source must hold its color until its gated strobe.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [6:0] X_LAST   = 7'(C_x_max);
    localparam logic [7:0] Y_LAST   = 8'(C_y_max);
    localparam logic [7:0] HOLD_MIN = 8'(C_hold_frames);

    state_t     state;
    state_t     state_nx;
    logic [7:0] hold;
    logic [7:0] hold_inc;
    logic [7:0] hold_nx;
    logic       last;
    logic       last_nx;
    logic       frame_evt;

    assign frame_evt = next_pixel && (x == X_LAST) && (y == Y_LAST);
    assign hold_inc  = (hold >= HOLD_MIN) ? hold : hold + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= 8'd0;
            last      <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            last      <= last_nx;
            frame_end <= frame_evt;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (frame_evt) begin
                    case (req)
                        2'b01:   state_nx = OWN0;
                        2'b10:   state_nx = OWN1;
                        2'b11:   state_nx = last ? OWN0 : OWN1;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            OWN0: begin
                if (frame_evt) begin
                    if (!req[0])
                        state_nx = req[1] ? OWN1 : IDLE;
                    else if (req[1] && (hold_inc >= HOLD_MIN))
                        state_nx = OWN1;
                end
            end
            OWN1: begin
                if (frame_evt) begin
                    if (!req[1])
                        state_nx = req[0] ? OWN0 : IDLE;
                    else if (req[0] && (hold_inc >= HOLD_MIN))
                        state_nx = OWN0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Hold count restarts with every new owner; last tracks the latest owner.
    always_comb begin
        hold_nx = hold;
        last_nx = last;
        if (state_nx != state)
            hold_nx = 8'd0;
        else if (frame_evt && (state != IDLE))
            hold_nx = hold_inc;
        if (state_nx == OWN0)
            last_nx = 1'b0;
        else if (state_nx == OWN1)
            last_nx = 1'b1;
    end

    always_comb begin
        grant = 2'b00;
        color = C_idle_color;
        case (state)
            OWN0: begin
                grant = 2'b01;
                color = src0_color;
            end
            OWN1: begin
                grant = 2'b10;
                color = src1_color;
            end
            default: begin
                grant = 2'b00;
                color = C_idle_color;
            end
        endcase
        src_next_pixel = {next_pixel & grant[1], next_pixel & grant[0]};
    end

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Bench for oled_frame_arbiter: a small frame size, a scanner that plays
// oled_video, and per-frame expected owners queued by the stimulus.
module tb_oled_frame_arbiter;

    localparam int          FX     = 15;
    localparam int          FY     = 7;
    localparam int          HOLD   = 2;
    localparam logic [6:0]  XL     = 7'd15;
    localparam logic [7:0]  YL     = 8'd7;
    localparam logic [15:0] IDLE_C = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  x = 7'd0;
    logic [7:0]  y = 8'd0;
    logic        next_pixel = 1'b0;
    logic [15:0] color;
    logic [1:0]  req = 2'b00;
    logic [15:0] src0_color = 16'hF800;
    logic [15:0] src1_color = 16'h001F;
    logic [1:0]  src_next_pixel;
    logic [1:0]  grant;
    logic        frame_end;

    always #5 clk = ~clk;

    oled_frame_arbiter #(
        .C_color_bits (16),
        .C_x_max      (FX),
        .C_y_max      (FY),
        .C_hold_frames(HOLD),
        .C_idle_color (IDLE_C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .next_pixel    (next_pixel),
        .color         (color),
        .req           (req),
        .src0_color    (src0_color),
        .src1_color    (src1_color),
        .src_next_pixel(src_next_pixel),
        .grant         (grant),
        .frame_end     (frame_end)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur_exp = 2'b00;
    logic       e_d = 1'b0;
    logic       rst_d = 1'b1;
    logic       mon_en = 1'b0;
    logic [6:0] bx = 7'd0;
    logic [7:0] by = 8'd0;
    int         gap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_color(input logic [1:0] g);
        case (g)
            2'b01:   return src0_color;
            2'b10:   return src1_color;
            default: return IDLE_C;
        endcase
    endfunction

    // Scanner: present (bx,by); on a strobe, advance in raster order.
    task automatic pix(input logic np);
        next_pixel = np;
        x = bx;
        y = by;
        @(posedge clk);
        #1;
        if (np) begin
            if (bx == XL) begin
                bx = 7'd0;
                by = (by == YL) ? 8'd0 : by + 8'd1;
            end else begin
                bx = bx + 7'd1;
            end
        end
        next_pixel = 1'b0;
    endtask

    task automatic run_to(input logic [6:0] tx, input logic [7:0] ty);
        while (!(bx == tx && by == ty)) begin
            gap_cnt++;
            pix((gap_cnt % 5) != 0);
        end
    endtask

    // Finish the current frame; g is the owner expected for the next frame.
    task automatic end_frame(input logic [1:0] g, input logic rst_at_e);
        run_to(XL, YL);
        pix(1'b0);
        if (!rst_at_e) exp_q.push_back(g);
        reset = rst_at_e;
        pix(1'b1);
        reset = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        pix(1'b1);
        reset = 1'b0;
    endtask

    // Monitor: owner updates on frame_end pops; every cycle checks outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("frame_end", 32'(frame_end), 32'(e_d && !rst_d));
                if (rst_d) begin
                    cur_exp = 2'b00;
                end else if (frame_end === 1'b1) begin
                    if (exp_q.size() == 0)
                        chk("grant_queue_depth", 32'(exp_q.size()), 32'd1);
                    else
                        cur_exp = exp_q.pop_front();
                end
                chk("grant", 32'(grant), 32'(cur_exp));
                chk("color", 32'(color), 32'(exp_color(cur_exp)));
                chk("src_next_pixel", 32'(src_next_pixel), 32'({2{next_pixel}} & cur_exp));
                e_d   = next_pixel && (x == XL) && (y == YL);
                rst_d = reset;
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog at %0t: simulation did not complete", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        pix(1'b0);
        mon_en = 1'b1;
        pix(1'b0);
        pix(1'b0);
        reset = 1'b0;

        // Single requester from reset, then owner drops mid-frame.
        req = 2'b01;
        end_frame(2'b01, 1'b0);
        end_frame(2'b01, 1'b0);
        run_to(7'd5, 8'd3);
        req = 2'b00;
        end_frame(2'b00, 1'b0);

        // Idle with last=0: tie goes to source 1, then alternate every 2 frames.
        req = 2'b11;
        end_frame(2'b10, 1'b0);
        end_frame(2'b10, 1'b0);
        end_frame(2'b01, 1'b0);
        src0_color = 16'h07E0;
        src1_color = 16'hFFFF;
        end_frame(2'b01, 1'b0);
        end_frame(2'b10, 1'b0);

        // Reset mid-frame while OWN1; re-grant goes to source 0 (last=1).
        run_to(7'd10, 8'd5);
        reset_pulse();
        end_frame(2'b01, 1'b0);
        src0_color = 16'hF800;
        src1_color = 16'h001F;
        end_frame(2'b01, 1'b0);
        end_frame(2'b10, 1'b0);
        end_frame(2'b10, 1'b0);
        end_frame(2'b01, 1'b0);

        // Reset coincident with the frame end: no grant, no frame_end.
        end_frame(2'b00, 1'b1);
        req = 2'b10;
        end_frame(2'b10, 1'b0);

        // Owner loses its request: switch immediately, no hold wait.
        req = 2'b01;
        end_frame(2'b01, 1'b0);
        run_to(7'd8, 8'd4);
        req = 2'b10;
        end_frame(2'b10, 1'b0);
        req = 2'b00;
        end_frame(2'b00, 1'b0);

        // A request pulse between frame boundaries is ignored.
        run_to(7'd2, 8'd2);
        req = 2'b01;
        run_to(7'd6, 8'd2);
        req = 2'b00;
        end_frame(2'b00, 1'b0);

        repeat (4) pix(1'b0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
